// File: rtl/db_pkg.sv
// db_pkg: shared FSM encodings, default debounce wait and counter-width helper for db_scan_ctrl.
package db_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;
  localparam int DEF_WAIT = 3;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/db_tick_gen.sv
// db_tick_gen: free-running prescaler gated by en; tick is high while the count sits at zero.
module db_tick_gen #(
  parameter int N_TICK = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [N_TICK-1:0] q_q, q_d;
  always_comb q_d = en ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign tick = en & (q_q == '0);
endmodule

// File: rtl/db_scan_ctrl.sv
// db_scan_ctrl: round-robin multi-channel switch debouncer; DB_SYNC_EN adds a 2-flop input synchronizer.
module db_scan_ctrl
  import db_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int N_TICK = 19,
  parameter int WAIT   = DEF_WAIT
) (
  input  logic                    clk_amisha,
  input  logic                    reset_amisha,
  input  logic                    en_amisha,
  input  logic [N_CH-1:0]         sw_amisha,
  output logic [N_CH-1:0]         db_amisha,
  output logic [N_CH-1:0]         rise_amisha,
  output logic [N_CH-1:0]         fall_amisha,
  output logic [$clog2(N_CH)-1:0] ch_amisha,
  output logic                    overrun_amisha
);
  localparam int CW = $clog2(N_CH);
  localparam int NW = cnt_w(WAIT);
  logic            tick, s;
  logic [N_CH-1:0] sw_s;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [N_CH-1:0] db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  logic [NW-1:0]   cnt_q [N_CH];
  logic [NW-1:0]   cnt_d [N_CH];
  logic            ovr_q, ovr_d, last;
  db_tick_gen #(.N_TICK(N_TICK)) u_tick (
    .clk  (clk_amisha),
    .rst  (reset_amisha),
    .en   (en_amisha),
    .tick (tick)
  );
`ifdef DB_SYNC_EN
  logic [N_CH-1:0] s1_q, s2_q;
  always_ff @(posedge clk_amisha) begin
    s1_q <= reset_amisha ? '0 : sw_amisha;
    s2_q <= reset_amisha ? '0 : s1_q;
  end
  assign sw_s = s2_q;
`else
  assign sw_s = sw_amisha;
`endif
  assign s    = sw_s[ch_q];
  assign last = ch_q == CW'(N_CH - 1);
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    ovr_d   = ovr_q | (tick & (state_q == ST_SCAN));
    if (state_q == ST_IDLE) begin
      state_d = tick ? ST_SCAN : ST_IDLE;
      ch_d    = '0;
    end else begin
      state_d = last ? ST_IDLE : ST_SCAN;
      ch_d    = last ? '0 : ch_q + 1'b1;
      if (s == db_q[ch_q]) cnt_d[ch_q] = '0;
      else if (cnt_q[ch_q] == NW'(WAIT - 1)) begin
        db_d[ch_q]   = s;
        cnt_d[ch_q]  = '0;
        rise_d[ch_q] = s;
        fall_d[ch_q] = ~s;
      end else cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
    end
  end
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      db_q    <= '0;
      cnt_q   <= '{default: '0};
      rise_q  <= '0;
      fall_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ovr_q   <= ovr_d;
    end
  end
  assign db_amisha      = db_q;
  assign rise_amisha    = rise_q;
  assign fall_amisha    = fall_q;
  assign ch_amisha      = ch_q;
  assign overrun_amisha = ovr_q;
endmodule
